// File: rtl/dmem_lsu_pkg.sv
// Shared types and encodings for the data-memory load/store unit.
package dmem_lsu_pkg;

    // Access sequencer states.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_DONE = 2'd3
    } lsu_state_e;

    // Access size lives in funct3[1:0]; funct3[2] selects zero-extension for loads.
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam int         F3_USIGN_BIT = 2;

    // Byte-lane geometry of the bus.
    localparam int BYTE_W = 8;
    localparam int BE_W   = 4;
    localparam logic [BE_W-1:0] BE_HALF_LO = 4'b0011;
    localparam logic [BE_W-1:0] BE_HALF_HI = 4'b1100;
    localparam logic [BE_W-1:0] BE_WORD    = 4'b1111;

    // Half-words need addr[0]=0, words need addr[1:0]=0; bytes are always aligned.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        case (funct3[1:0])
            SZ_HALF:         bad = addr_lo[0];
            SZ_WORD, 2'b11:  bad = (addr_lo != 2'b00);
            default:         bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Word-wide memory bus between the load/store unit and the data memory.
interface dmem_lsu_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int WORD_WIDTH = 32
);
    import dmem_lsu_pkg::*;

    logic                  bus_req_valid;
    logic                  bus_req_ready;
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic                  bus_we;
    logic [BE_W-1:0]       bus_be;
    logic [WORD_WIDTH-1:0] bus_wdata;
    logic                  bus_rsp_valid;
    logic [WORD_WIDTH-1:0] bus_rdata;

    modport master (
        output bus_req_valid, bus_addr, bus_we, bus_be, bus_wdata,
        input  bus_req_ready, bus_rsp_valid, bus_rdata
    );

    modport slave (
        input  bus_req_valid, bus_addr, bus_we, bus_be, bus_wdata,
        output bus_req_ready, bus_rsp_valid, bus_rdata
    );

endinterface

// File: rtl/dmem_lsu_lane.sv
// Byte-lane steering: store data placement / byte enables and load extraction / extension.
// Assumes a 32-bit word split into four byte lanes.
module dmem_lsu_lane
    import dmem_lsu_pkg::*;
#(
    parameter int WORD_WIDTH = 32
) (
    input  logic [1:0]            addr_lo,
    input  logic [2:0]            funct3,
    input  logic [WORD_WIDTH-1:0] wdata,
    input  logic [WORD_WIDTH-1:0] rdata,
    output logic [BE_W-1:0]       be,
    output logic [WORD_WIDTH-1:0] wdata_lane,
    output logic [WORD_WIDTH-1:0] rdata_ext
);

    localparam int HALF_W = 2 * BYTE_W;

    logic [BYTE_W-1:0] rd_byte;
    logic [HALF_W-1:0] rd_half;
    logic              sext;

    assign rd_byte = rdata[{addr_lo, 3'b000} +: BYTE_W];
    assign rd_half = rdata[{addr_lo[1], 4'b0000} +: HALF_W];
    assign sext    = ~funct3[F3_USIGN_BIT];

    // Replicate narrow store data across lanes and enable only the addressed bytes.
    always_comb begin
        be         = BE_WORD;
        wdata_lane = wdata;
        case (funct3[1:0])
            SZ_BYTE: begin
                be         = BE_W'(1) << addr_lo;
                wdata_lane = {BE_W{wdata[BYTE_W-1:0]}};
            end
            SZ_HALF: begin
                be         = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
                wdata_lane = {2{wdata[HALF_W-1:0]}};
            end
            default: ;
        endcase
    end

    // Pick the addressed byte/half-word from the read word and sign- or zero-extend it.
    always_comb begin
        rdata_ext = rdata;
        case (funct3[1:0])
            SZ_BYTE: rdata_ext = {{(WORD_WIDTH-BYTE_W){rd_byte[BYTE_W-1] & sext}}, rd_byte};
            SZ_HALF: rdata_ext = {{(WORD_WIDTH-HALF_W){rd_half[HALF_W-1] & sext}}, rd_half};
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Data-memory load/store unit: turns core DMEM-stage requests into single bus
// transactions, stalling the core until the access completes or times out.
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int WORD_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic [WORD_WIDTH-1:0] core_wdata,
    input  logic                  core_read,
    input  logic                  core_write,
    input  logic [2:0]            core_funct3,
    output logic [WORD_WIDTH-1:0] core_rdata,
    output logic                  core_stall,
    output logic                  core_err,
    dmem_lsu_if.master            bus
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    lsu_state_e            state;
    logic [CNT_W-1:0]      wait_cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [WORD_WIDTH-1:0] wdata_q;
    logic [2:0]            funct3_q;
    logic                  write_q;
    logic [WORD_WIDTH-1:0] rdata_q;
    logic                  err_q;

    logic                  core_req;
    logic                  req_bad;
    logic                  req_ok;
    logic                  wait_last;
    logic                  in_req;
    logic [BE_W-1:0]       lane_be;
    logic [WORD_WIDTH-1:0] lane_wdata;
    logic [WORD_WIDTH-1:0] lane_rdata;

    assign core_req  = core_read | core_write;
    assign req_bad   = (core_read & core_write) | is_misaligned(core_funct3, core_addr[1:0]);
    assign req_ok    = core_req & ~req_bad;
    // The counter holds the number of REQ/RESP cycles already spent; this is the last allowed one.
    assign wait_last = (wait_cnt >= CNT_W'(TIMEOUT_CYCLES - 1));
    assign in_req    = (state == S_REQ);

    dmem_lsu_lane #(.WORD_WIDTH(WORD_WIDTH)) u_lane (
        .addr_lo    (addr_q[1:0]),
        .funct3     (funct3_q),
        .wdata      (wdata_q),
        .rdata      (bus.bus_rdata),
        .be         (lane_be),
        .wdata_lane (lane_wdata),
        .rdata_ext  (lane_rdata)
    );

    // Bus request fields come only from the latched request, so they hold steady until accepted.
    assign bus.bus_req_valid = in_req;
    assign bus.bus_addr      = in_req ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
    assign bus.bus_we        = in_req & write_q;
    assign bus.bus_be        = in_req ? lane_be : '0;
    assign bus.bus_wdata     = in_req ? lane_wdata : '0;

    // A legal request stalls the core in its very first cycle; rst_n masks the combinational paths.
    assign core_stall = rst_n & ((state == S_REQ) | (state == S_RESP) | ((state == S_IDLE) & req_ok));
    assign core_err   = rst_n & (((state == S_IDLE) & core_req & req_bad) | ((state == S_DONE) & err_q));
    assign core_rdata = (state == S_DONE) ? rdata_q : '0;

    // Access sequencer with wait counter and request/result latches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            funct3_q <= '0;
            write_q  <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (req_ok) begin
                        addr_q   <= core_addr;
                        wdata_q  <= core_wdata;
                        funct3_q <= core_funct3;
                        write_q  <= core_write;
                        wait_cnt <= '0;
                        rdata_q  <= '0;
                        err_q    <= 1'b0;
                        state    <= S_REQ;
                    end
                end
                S_REQ: begin
                    wait_cnt <= wait_cnt + CNT_W'(1);
                    // An acceptance on the final wait cycle still counts as a handshake.
                    if (bus.bus_req_ready) begin
                        state <= write_q ? S_DONE : S_RESP;
                    end else if (wait_last) begin
                        err_q <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_RESP: begin
                    if (bus.bus_rsp_valid) begin
                        rdata_q <= lane_rdata;
                        state   <= S_DONE;
                    end else if (wait_last) begin
                        err_q <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    err_q <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
